// File: rtl/fetch_pc_unit.sv
// Multi-slot fetch program counter: one aligned group of FETCH_WIDTH slots per accepted cycle.
// Optional FETCH_PERF_CNT_EN macro adds saturating accepted-group and redirect counters.
module fetch_pc_unit #(
    parameter int                XLEN            = 32,
    parameter int                FETCH_WIDTH     = 2,
    parameter logic [XLEN-1:0]   RESET_PC        = '0,
    parameter int                REDIRECT_BUBBLE = 1,
    localparam int               SLOT_W          = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [XLEN-1:0]        correct_pc,
    input  logic                   fetch_ready,
    input  logic                   bp_taken,
    input  logic [SLOT_W-1:0]      bp_slot,
    input  logic [XLEN-1:0]        bp_target,
    input  logic                   stop_fetch,
    output logic [XLEN-1:0]        pc,
    output logic                   fetch_valid,
    output logic [FETCH_WIDTH-1:0] slot_mask,
    output logic                   halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_groups,
    output logic [31:0]            perf_redirects
`endif
);

    localparam int              OFF_W       = $clog2(FETCH_WIDTH * 4);
    localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(FETCH_WIDTH * 4);
    localparam logic [2:0]      BUB_LOAD    = 3'(REDIRECT_BUBBLE - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_BUBBLE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [SLOT_W-1:0] start_slot;
    logic [XLEN-1:0]   group_base;
    logic              taken_eff;
    logic              accept;
    logic              unused_low;

    generate
        if (FETCH_WIDTH > 1) begin : g_slot
            assign start_slot = pc_q[OFF_W-1:2];
        end else begin : g_noslot
            assign start_slot = '0;
        end
    endgenerate

    assign group_base  = {pc_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    // A taken branch in a slot before the entry point belongs to an older group.
    assign taken_eff   = bp_taken && (bp_slot >= start_slot);
    assign fetch_valid = (state_q == S_RUN);
    assign accept      = fetch_valid && fetch_ready;
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign unused_low  = ^{correct_pc[1:0], bp_target[1:0]};

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_mask
            localparam logic [SLOT_W-1:0] IDX = SLOT_W'(gi);
            assign slot_mask[gi] = fetch_valid && (IDX >= start_slot)
                                   && !(taken_eff && (IDX > bp_slot));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            pc_d = {correct_pc[XLEN-1:2], 2'b00};
            if (REDIRECT_BUBBLE > 0) begin
                state_d = S_BUBBLE;
                cnt_d   = BUB_LOAD;
            end else begin
                state_d = S_RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop_fetch) begin
                        state_d = S_HALT;
                    end else if (accept) begin
                        pc_d = taken_eff ? {bp_target[XLEN-1:2], 2'b00}
                                         : group_base + GROUP_BYTES;
                    end
                end
                S_BUBBLE: begin
                    if (stop_fetch) begin
                        state_d = S_HALT;
                    end else if (cnt_q == 3'd0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_groups_q, perf_redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_groups_q    <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (accept && (perf_groups_q != '1)) begin
                perf_groups_q <= perf_groups_q + 32'd1;
            end
            if (flush && (perf_redirects_q != '1)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_groups    = perf_groups_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, flush, fetch_ready, bp_taken, stop_fetch;
    logic [31:0] correct_pc, bp_target;
    logic [0:0]  bp_slot;
    logic [31:0] pc;
    logic        fetch_valid, halted;
    logic [1:0]  slot_mask;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_groups, perf_redirects;
    logic [31:0] m_groups, m_redirects;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: pc, halt flag, remaining invalid cycles after a redirect
    logic [31:0] m_pc;
    bit          m_halted;
    int          m_bub;

    fetch_pc_unit #(
        .XLEN(32), .FETCH_WIDTH(2), .RESET_PC(32'h0), .REDIRECT_BUBBLE(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .correct_pc(correct_pc),
        .fetch_ready(fetch_ready), .bp_taken(bp_taken), .bp_slot(bp_slot),
        .bp_target(bp_target), .stop_fetch(stop_fetch), .pc(pc),
        .fetch_valid(fetch_valid), .slot_mask(slot_mask), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_groups(perf_groups), .perf_redirects(perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_valid();
        return !m_halted && (m_bub == 0);
    endfunction

    function automatic bit m_taken();
        int s = (m_pc % 8) / 4;
        return bp_taken && (int'(bp_slot) >= s);
    endfunction

    function automatic logic [1:0] m_mask();
        logic [1:0] r = 2'b00;
        int s = (m_pc % 8) / 4;
        if (!m_valid()) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (i >= s && (!m_taken() || i <= int'(bp_slot))) r[i] = 1'b1;
        return r;
    endfunction

    task automatic drive(input bit r, input bit f, input logic [31:0] c, input bit rdy,
                         input bit tk, input logic s, input logic [31:0] t, input bit st);
        rst = r; flush = f; correct_pc = c; fetch_ready = rdy;
        bp_taken = tk; bp_slot = s; bp_target = t; stop_fetch = st;
        #1;
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = m_valid() && fetch_ready;
        if (rst) begin
            m_pc = 32'h0; m_halted = 0; m_bub = 0;
`ifdef FETCH_PERF_CNT_EN
            m_groups = 0; m_redirects = 0;
`endif
        end else begin
`ifdef FETCH_PERF_CNT_EN
            if (acc && m_groups != 32'hFFFF_FFFF) m_groups++;
            if (flush && m_redirects != 32'hFFFF_FFFF) m_redirects++;
`endif
            if (flush) begin
                m_pc = correct_pc & ~32'h3; m_bub = 1; m_halted = 0;
            end else if (m_halted) begin
                m_halted = 1;
            end else if (stop_fetch) begin
                m_halted = 1; m_bub = 0;
            end else if (m_bub > 0) begin
                m_bub--;
            end else if (acc) begin
                if (m_taken()) m_pc = bp_target & ~32'h3;
                else m_pc = (m_pc - (m_pc % 8)) + 32'd8;
            end
        end
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        drive(0, 1, a, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (pc !== 32'h0 || fetch_valid !== 1'b1 || slot_mask !== 2'b11 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: pc=%h valid=%b mask=%b halted=%b, want 0 1 11 0",
                     pc, fetch_valid, slot_mask, halted);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (perf_groups !== 32'h0 || perf_redirects !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf: groups=%0d redirects=%0d want 0 0", perf_groups, perf_redirects);
        end
`endif
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            vectors++;
            if (pc !== 32'(i * 8) || slot_mask !== 2'b11 || fetch_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL sequential[%0d]: pc=%h mask=%b valid=%b, want %h 11 1",
                         i, pc, slot_mask, fetch_valid, 32'(i * 8));
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(0, 1, 32'h105, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (fetch_valid !== 1'b0 || slot_mask !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_bubble: valid=%b mask=%b, want 0 00", fetch_valid, slot_mask);
        end
        tick();
        vectors++;
        if (pc !== 32'h104 || slot_mask !== 2'b10 || fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_target: pc=%h mask=%b valid=%b, want 104 10 1", pc, slot_mask, fetch_valid);
        end
        tick();
        vectors++;
        if (pc !== 32'h108) begin
            miscompares++;
            $display("FAIL flush_next: pc=%h, want 108", pc);
        end
    endtask

    task automatic test_branch();
        redirect_to(32'h20);
        drive(0, 0, 0, 1, 1, 1'b0, 32'h43, 0);
        vectors++;
        if (slot_mask !== 2'b01) begin
            miscompares++;
            $display("FAIL branch_mask: mask=%b, want 01", slot_mask);
        end
        tick();
        vectors++;
        if (pc !== 32'h40) begin
            miscompares++;
            $display("FAIL branch_target: pc=%h, want 40", pc);
        end
        redirect_to(32'h24);
        drive(0, 0, 0, 1, 1, 1'b0, 32'h80, 0);
        vectors++;
        if (slot_mask !== 2'b10) begin
            miscompares++;
            $display("FAIL branch_ignored_mask: mask=%b, want 10", slot_mask);
        end
        tick();
        vectors++;
        if (pc !== 32'h28) begin
            miscompares++;
            $display("FAIL branch_ignored: pc=%h, want 28", pc);
        end
    endtask

    task automatic test_stall();
        redirect_to(32'h30);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (pc !== 32'h30 || fetch_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall[%0d]: pc=%h valid=%b, want 30 1", i, pc, fetch_valid);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
        vectors++;
        if (pc !== 32'h38) begin
            miscompares++;
            $display("FAIL stall_release: pc=%h, want 38", pc);
        end
    endtask

    task automatic test_halt();
        redirect_to(32'h50);
        drive(0, 0, 0, 1, 0, 0, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 0);
            vectors++;
            if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h50 || slot_mask !== 2'b00) begin
                miscompares++;
                $display("FAIL halt[%0d]: halted=%b valid=%b pc=%h mask=%b, want 1 0 50 00",
                         i, halted, fetch_valid, pc, slot_mask);
            end
            tick();
        end
        drive(0, 1, 32'h60, 1, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (halted !== 1'b0 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_restart: halted=%b valid=%b, want 0 0", halted, fetch_valid);
        end
        tick();
        vectors++;
        if (pc !== 32'h60 || fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_resume: pc=%h valid=%b, want 60 1", pc, fetch_valid);
        end
        // reset in the middle of a bubble
        drive(0, 1, 32'h200, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (pc !== 32'h0 || fetch_valid !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_bubble: pc=%h valid=%b halted=%b, want 0 1 0", pc, fetch_valid, halted);
        end
    endtask

    task automatic test_wrap();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] g0, r0;
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
`endif
        redirect_to(32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        g0 = perf_groups; r0 = perf_redirects;
`endif
        drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
        vectors++;
        if (pc !== 32'h0 || fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap: pc=%h valid=%b, want 0 1", pc, fetch_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (perf_groups !== g0 + 32'd1 || perf_redirects !== r0 || r0 !== 32'd1) begin
            miscompares++;
            $display("FAIL wrap_perf: groups=%0d redirects=%0d, want %0d 1", perf_groups, perf_redirects, g0 + 1);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, 1'($urandom),
                  $urandom, $urandom_range(0, 99) < 5);
            vectors++;
            if (pc !== m_pc || fetch_valid !== m_valid() || slot_mask !== m_mask() || halted !== m_halted) begin
                miscompares++;
                $display("FAIL random[%0d]: pc=%h/%h valid=%b/%b mask=%b/%b halted=%b/%b (got/want)",
                         i, pc, m_pc, fetch_valid, m_valid(), slot_mask, m_mask(), halted, m_halted);
            end
`ifdef FETCH_PERF_CNT_EN
            vectors++;
            if (perf_groups !== m_groups || perf_redirects !== m_redirects) begin
                miscompares++;
                $display("FAIL random_perf[%0d]: groups=%0d/%0d redirects=%0d/%0d (got/want)",
                         i, perf_groups, m_groups, perf_redirects, m_redirects);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_pc = 0; m_halted = 0; m_bub = 0;
`ifdef FETCH_PERF_CNT_EN
        m_groups = 0; m_redirects = 0;
`endif
        test_reset();
        test_sequential();
        test_flush();
        test_branch();
        test_stall();
        test_halt();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
